// File: rtl/ternary_matvec_pkg.sv
// Shared definitions for the ternary matrix-vector engine: weight codes,
// FSM state encoding and the output conversion helper.
// Optional build macro: TERNARY_MATVEC_SAT_EN (saturate instead of truncate).
package ternary_matvec_pkg;

  // Two-bit ternary weight code; the upper bit set always means -1.
  localparam logic [1:0] W_ZERO    = 2'b00;
  localparam logic [1:0] W_POS     = 2'b01;
  localparam int         W_NEG_BIT = 1;

  // FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  // Convert a sign-extended accumulator value to a bw-bit output element.
  // Callers take the low bw bits of the returned word.
  function automatic logic [63:0] sat_or_trunc(input logic signed [63:0] a,
                                               input int unsigned bw);
`ifdef TERNARY_MATVEC_SAT_EN
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (bw - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (bw - 1));
    if (a > max_v) return max_v;
    else if (a < min_v) return min_v;
    else return a;
`else
    logic [63:0] mask;
    mask = (64'd1 << bw) - 64'd1;
    return a & mask;
`endif
  endfunction

endpackage

// File: rtl/ternary_matvec_dot.sv
// Per-column ternary dot product over one beat: each lane is added,
// subtracted or skipped according to its weight code.
module ternary_dot
  import ternary_matvec_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 12
) (
  input  logic [LANES*BIT_WIDTH-1:0] lane_data,
  input  logic [2*LANES-1:0]         codes,
  output logic [ACC_WIDTH-1:0]       dot
);

  logic [ACC_WIDTH-1:0] lane_ext;

  // Sign-extend each lane and fold it into the sum by its ternary code.
  always_comb begin
    dot      = '0;
    lane_ext = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_ext = ACC_WIDTH'($signed(lane_data[k*BIT_WIDTH +: BIT_WIDTH]));
      case (codes[2*k +: 2])
        W_ZERO:  dot = dot;
        W_POS:   dot = dot + lane_ext;
        default: dot = dot - lane_ext;
      endcase
    end
  end

endmodule

// File: rtl/ternary_matvec.sv
// Ternary-weight matrix-vector engine. Weights are written per beat-row
// while idle; an input frame of IN_LEN/LANES beats is accumulated into
// OUT_LEN column sums, which are then streamed out one element per transfer.
// Optional build macro: TERNARY_MATVEC_SAT_EN (saturating output conversion).
module ternary_matvec
  import ternary_matvec_pkg::*;
#(
  parameter int IN_LEN    = 16,
  parameter int OUT_LEN   = 8,
  parameter int BIT_WIDTH = 8,
  parameter int LANES     = 2,
  parameter int ACC_WIDTH = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              w_we,
  input  logic [$clog2(IN_LEN/LANES)-1:0]   w_addr,
  input  logic [LANES*2*OUT_LEN-1:0]        w_data,
  output logic                              w_ready,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*BIT_WIDTH-1:0]        in_data,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BIT_WIDTH-1:0]              out_data,
  output logic [$clog2(OUT_LEN)-1:0]        out_idx,
  output logic                              out_last,
  output logic                              frame_err,
  output logic                              busy
);

  localparam int BEATS = IN_LEN / LANES;
  localparam int AW    = $clog2(BEATS);
  localparam int IW    = $clog2(OUT_LEN);
  localparam int ROW_W = LANES * 2 * OUT_LEN;
  localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(OUT_LEN - 1);

  state_t               state;
  logic [AW-1:0]        beat_cnt;
  logic [ROW_W-1:0]     wmem [BEATS];
  logic [ROW_W-1:0]     cur_row;
  logic [ACC_WIDTH-1:0] acc  [OUT_LEN];
  logic [ACC_WIDTH-1:0] dot  [OUT_LEN];
  logic signed [ACC_WIDTH-1:0] acc_sel;
  logic                 beat_fire;
  logic                 beat_wrap;

  assign w_ready   = (state == ST_IDLE);
  assign in_ready  = (state != ST_DRAIN);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DRAIN);
  assign out_last  = out_valid & (out_idx == LAST_IDX);
  assign beat_fire = in_valid & in_ready;
  assign beat_wrap = (beat_cnt == LAST_BEAT);
  assign cur_row   = wmem[beat_cnt];

  // Weight storage is deliberately left out of reset so it survives rst.
  always_ff @(posedge clk) begin
    if (w_we && w_ready) begin
      wmem[w_addr] <= w_data;
    end
  end

  // One dot-product unit per output column, fed by that column's codes.
  for (genvar j = 0; j < OUT_LEN; j++) begin : g_col
    logic [2*LANES-1:0] codes;

    // Gather this column's codes for the current beat's LANES rows.
    always_comb begin
      codes = '0;
      for (int k = 0; k < LANES; k++) begin
        codes[2*k +: 2] = cur_row[k*2*OUT_LEN + 2*j +: 2];
      end
    end

    ternary_dot #(
      .LANES     (LANES),
      .BIT_WIDTH (BIT_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_dot (
      .lane_data (in_data),
      .codes     (codes),
      .dot       (dot[j])
    );
  end

  // Frame sequencing, accumulation, error pulse and output indexing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      out_idx   <= '0;
      frame_err <= 1'b0;
      for (int j = 0; j < OUT_LEN; j++) begin
        acc[j] <= '0;
      end
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (beat_fire) begin
            frame_err <= in_last ^ beat_wrap;
            for (int j = 0; j < OUT_LEN; j++) begin
              acc[j] <= (state == ST_IDLE) ? dot[j] : acc[j] + dot[j];
            end
            if (beat_wrap) begin
              beat_cnt <= '0;
              state    <= ST_DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              state    <= ST_ACCUM;
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (out_idx == LAST_IDX) begin
              out_idx <= '0;
              state   <= ST_IDLE;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output element is the selected accumulator, saturated or truncated.
  always_comb begin
    acc_sel  = acc[out_idx];
    out_data = BIT_WIDTH'(sat_or_trunc(64'(acc_sel), BIT_WIDTH));
  end

endmodule

// File: tb/tb_ternary_matvec.sv
// Directed self-checking bench for ternary_matvec (default parameters).
module tb_ternary_matvec;

  localparam int IN_LEN    = 16;
  localparam int OUT_LEN   = 8;
  localparam int BIT_WIDTH = 8;
  localparam int LANES     = 2;
  localparam int ACC_WIDTH = 12;
  localparam int BEATS     = IN_LEN / LANES;

  localparam int P_POS  = 0;
  localparam int P_NEG  = 1;
  localparam int P_TRI  = 2;
  localparam int P_LANE = 3;

  logic        clk;
  logic        rst;
  logic        w_we;
  logic [2:0]  w_addr;
  logic [31:0] w_data;
  logic        w_ready;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        frame_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] expData [OUT_LEN];

  ternary_matvec #(
    .IN_LEN    (IN_LEN),
    .OUT_LEN   (OUT_LEN),
    .BIT_WIDTH (BIT_WIDTH),
    .LANES     (LANES),
    .ACC_WIDTH (ACC_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight code for row r (lane k) and column j under a named pattern.
  function automatic logic [1:0] codeFor(input int pat, input int r, input int k, input int j);
    case (pat)
      P_POS:   return 2'b01;
      P_NEG:   return 2'b11;
      P_TRI:   return (r < 2*j + 2) ? 2'b01 : 2'b00;
      default: return (k == 0) ? ((j % 2 == 0) ? 2'b01 : 2'b00)
                               : ((j % 2 == 0) ? 2'b10 : 2'b01);
    endcase
  endfunction

  // Packed w_data word for beat-row address a.
  function automatic logic [31:0] rowWord(input int pat, input int a);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++)
      for (int j = 0; j < OUT_LEN; j++)
        v[k*2*OUT_LEN + 2*j +: 2] = codeFor(pat, a*LANES + k, k, j);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] l0, input logic [7:0] l1, input logic last);
    in_valid = 1'b1;
    in_data  = {l1, l0};
    in_last  = last;
  endtask

  task automatic loadWeights(input int pat);
    for (int a = 0; a < BEATS; a++) begin
      @(negedge clk);
      w_we   = 1'b1;
      w_addr = 3'(a);
      w_data = rowWord(pat, a);
    end
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic sendFrame(input string tag, input logic [7:0] l0, input logic [7:0] l1,
                           input logic [7:0] lastMask, input logic [7:0] errMask,
                           input bit dropWrite);
    for (int b = 0; b < BEATS; b++) begin
      @(negedge clk);
      if (b > 0) begin
        checkOutput({tag, " frame_err"}, 32'(frame_err), 32'(errMask[b-1]));
        checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        checkOutput({tag, " w_ready"}, 32'(w_ready), 32'd0);
      end
      checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
      applyStimulus(l0, l1, lastMask[b]);
      if (dropWrite && b > 0) begin
        w_we   = 1'b1;
        w_addr = 3'(b);
        w_data = 32'hFFFF_FFFF;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    w_we     = 1'b0;
    checkOutput({tag, " frame_err end"}, 32'(frame_err), 32'(errMask[7]));
    checkOutput({tag, " in_ready drain"}, 32'(in_ready), 32'd0);
  endtask

  task automatic drainFrame(input string tag, input int stallAt, input int stallLen);
    for (int i = 0; i < OUT_LEN; i++) begin
      checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, " out_idx"}, 32'(out_idx), 32'(i));
      checkOutput({tag, " out_data"}, 32'(out_data), 32'(expData[i]));
      checkOutput({tag, " out_last"}, 32'(out_last), 32'(i == OUT_LEN - 1));
      if (i == stallAt) begin
        out_ready = 1'b0;
        for (int s = 0; s < stallLen; s++) begin
          @(negedge clk);
          checkOutput({tag, " held valid"}, 32'(out_valid), 32'd1);
          checkOutput({tag, " held idx"}, 32'(out_idx), 32'(i));
          checkOutput({tag, " held data"}, 32'(out_data), 32'(expData[i]));
          checkOutput({tag, " held last"}, 32'(out_last), 32'(i == OUT_LEN - 1));
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    checkOutput({tag, " idle valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " idle w_ready"}, 32'(w_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    w_we      = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst w_ready", 32'(w_ready), 32'd1);
    checkOutput("rst in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst frame_err", 32'(frame_err), 32'd0);
    checkOutput("rst out_data", 32'(out_data), 32'd0);
    checkOutput("rst out_idx", 32'(out_idx), 32'd0);
    checkOutput("rst out_last", 32'(out_last), 32'd0);
    rst = 1'b0;

    // All +1 weights, all inputs +1: every column sums 16 rows.
    loadWeights(P_POS);
    for (int j = 0; j < OUT_LEN; j++) expData[j] = 8'h10;
    sendFrame("pos", 8'd1, 8'd1, 8'h80, 8'h00, 1'b0);
    drainFrame("pos", -1, 0);

    // All -1 weights, inputs +10: accumulator -160.
    loadWeights(P_NEG);
`ifdef TERNARY_MATVEC_SAT_EN
    for (int j = 0; j < OUT_LEN; j++) expData[j] = 8'h80;
`else
    for (int j = 0; j < OUT_LEN; j++) expData[j] = 8'h60;
`endif
    sendFrame("neg", 8'd10, 8'd10, 8'h80, 8'h00, 1'b0);
    drainFrame("neg", -1, 0);

    // Column j uses the first 2j+2 rows: sums 2,4,...,16; stall at idx 3.
    loadWeights(P_TRI);
    for (int j = 0; j < OUT_LEN; j++) expData[j] = 8'(2*j + 2);
    sendFrame("stall", 8'd1, 8'd1, 8'h80, 8'h00, 1'b0);
    drainFrame("stall", 3, 3);

    // Lane mapping and mixed signs: lane0=3, lane1=-2.
    // Even cols: +3*8 - (-2)*8 = 40; odd cols: (-2)*8 = -16.
    loadWeights(P_LANE);
    for (int j = 0; j < OUT_LEN; j++) expData[j] = (j % 2 == 0) ? 8'h28 : 8'hF0;
    sendFrame("lane", 8'd3, 8'hFE, 8'h80, 8'h00, 1'b0);
    drainFrame("lane", -1, 0);

    // Early in_last on beat 3 flags an error but the frame still runs to beat 7.
    loadWeights(P_POS);
    for (int j = 0; j < OUT_LEN; j++) expData[j] = 8'h10;
    sendFrame("early_last", 8'd1, 8'd1, 8'h88, 8'h08, 1'b0);
    drainFrame("early_last", -1, 0);

    // Reset while beat 4 is presented: frame discarded, weights retained.
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      applyStimulus(8'd1, 8'd1, 1'b0);
    end
    @(negedge clk);
    applyStimulus(8'd1, 8'd1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst w_ready", 32'(w_ready), 32'd1);
    checkOutput("midrst frame_err", 32'(frame_err), 32'd0);
    checkOutput("midrst out_data", 32'(out_data), 32'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst no output", 32'(out_valid), 32'd0);
    end
    sendFrame("after_rst", 8'd1, 8'd1, 8'h80, 8'h00, 1'b0);
    drainFrame("after_rst", -1, 0);

    // Weight writes attempted during ACCUM are dropped.
    sendFrame("wdrop", 8'd1, 8'd1, 8'h80, 8'h00, 1'b1);
    drainFrame("wdrop", -1, 0);
    sendFrame("wdrop_next", 8'd1, 8'd1, 8'h80, 8'h00, 1'b0);
    drainFrame("wdrop_next", -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
